vr_data_mem_pipe: RTL and testbench

Parametrised successor to the single-cycle data memory, used as the data-side memory of the processor datapath.
- Adds a valid/ready request/response handshake, byte-lane write enables, configurable read latency, response back-pressure and out-of-range error reporting.
- Single port: one request accepted per cycle; every accepted request, read or write, produces exactly one response, in order.

---
 rtl/vr_data_mem_pipe_if.sv | 27 ++
 rtl/vr_data_mem_pipe.sv | 103 ++++++++++
 tb/tb_vr_data_mem_pipe.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vr_data_mem_pipe_if.sv
// Request/response bus for vr_data_mem_pipe: valid/ready request channel and
// valid/ready response channel with read data and error flag.
interface vr_data_mem_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     addr;
  logic                  rw;
  logic [DATA_W-1:0]     wd;
  logic [DATA_W/8-1:0]   be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rd;
  logic                  err;

  modport slave (
    input  req_valid, addr, rw, wd, be, rsp_ready,
    output req_ready, rsp_valid, rd, err
  );

  modport master (
    output req_valid, addr, rw, wd, be, rsp_ready,
    input  req_ready, rsp_valid, rd, err
  );
endinterface

// File: rtl/vr_data_mem_pipe.sv
// Pipelined single-port data memory with byte-lane writes and in-order responses.
// Optional VR_DMEM_CLR_ON_RST_EN: sweep the array to zero after reset before accepting requests.
module vr_data_mem_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned RD_LAT = 1
) (
  input logic               i_clk,
  input logic               i_rst_n,
  vr_data_mem_pipe_if.slave io_bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned NB    = DATA_W / 8;

  logic              w_adv;
  logic              w_acc;
  logic              w_oor;
  logic              w_wr;
  logic              w_run;
  logic              w_clr;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_clr_idx;
  logic [DATA_W-1:0] w_rd_data;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_err;
  logic [DATA_W-1:0] r_dat [RD_LAT];

  // Ready depends only on registered state and the consumer, never on req_valid.
  assign w_adv            = !r_vld[RD_LAT-1] || io_bus.rsp_ready;
  assign io_bus.req_ready = w_adv && w_run;
  assign w_acc            = io_bus.req_valid && io_bus.req_ready && i_rst_n;
  assign w_idx            = io_bus.addr[IDX_W+1:2];
  assign w_oor            = (io_bus.addr >> (IDX_W + 2)) != '0;
  assign w_wr             = w_acc && io_bus.rw && !w_oor;
  assign w_rd_data        = (io_bus.rw || w_oor) ? '0 : r_mem[w_idx];

`ifdef VR_DMEM_CLR_ON_RST_EN
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_init_idx;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_idx <= r_init_idx + 1'b1;
      if (r_init_idx == IDX_W'(DEPTH - 1)) begin
        r_state <= ST_RUN;
      end
    end
  end

  assign w_run     = (r_state == ST_RUN);
  assign w_clr     = (r_state == ST_INIT) && i_rst_n;
  assign w_clr_idx = r_init_idx;
`else
  assign w_run     = 1'b1;
  assign w_clr     = 1'b0;
  assign w_clr_idx = '0;
`endif

  // Array has no reset: contents survive RST_N unless the clear sweep is built in.
  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (io_bus.be[b]) begin
          r_mem[w_idx][8*b +: 8] <= io_bus.wd[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      r_err <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        r_dat[k] <= '0;
      end
    end else if (w_adv) begin
      r_vld[0] <= w_acc;
      r_err[0] <= w_acc && w_oor;
      r_dat[0] <= w_acc ? w_rd_data : '0;
      for (int k = 1; k < RD_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_err[k] <= r_err[k-1];
        r_dat[k] <= r_dat[k-1];
      end
    end
  end

  assign io_bus.rsp_valid = r_vld[RD_LAT-1];
  assign io_bus.rd        = r_dat[RD_LAT-1];
  assign io_bus.err       = r_err[RD_LAT-1];
endmodule

// File: tb/tb_vr_data_mem_pipe.sv
// Bench for vr_data_mem_pipe: two instances (RD_LAT=1 and RD_LAT=3) driven one at a time,
// responses checked against a queue of expected values built from a memory model.
module tb_vr_data_mem_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        d_req_valid;
  logic [31:0] d_addr;
  logic        d_rw;
  logic [31:0] d_wd;
  logic [3:0]  d_be;
  logic        d_rsp_ready;
  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rd;
  logic        o_err;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
    bit          lat_chk;
    int          lat;
  } sb_t;

  sb_t         sb[$];
  sb_t         mon_e;
  logic [31:0] model [2][256];

  vr_data_mem_pipe_if #(.DATA_W(32), .ADDR_W(32)) if1 ();
  vr_data_mem_pipe_if #(.DATA_W(32), .ADDR_W(32)) if3 ();

  vr_data_mem_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .RD_LAT(1)) u_dut1 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (if1)
  );

  vr_data_mem_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .RD_LAT(3)) u_dut3 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (if3)
  );

  assign if1.req_valid = d_req_valid && !sel;
  assign if3.req_valid = d_req_valid && sel;
  assign if1.addr      = d_addr;
  assign if3.addr      = d_addr;
  assign if1.rw        = d_rw;
  assign if3.rw        = d_rw;
  assign if1.wd        = d_wd;
  assign if3.wd        = d_wd;
  assign if1.be        = d_be;
  assign if3.be        = d_be;
  assign if1.rsp_ready = d_rsp_ready;
  assign if3.rsp_ready = d_rsp_ready;

  assign o_req_ready = sel ? if3.req_ready : if1.req_ready;
  assign o_rsp_valid = sel ? if3.rsp_valid : if1.rsp_valid;
  assign o_rd        = sel ? if3.rd        : if1.rd;
  assign o_err       = sel ? if3.err       : if1.err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard: every response handshake pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && o_rsp_valid && d_rsp_ready) begin
      checks++;
      assert (sb.size() != 0) begin
        passes++;
        mon_e = sb.pop_front();
        chk("rsp_rd", o_rd, mon_e.rd);
        chk("rsp_err", {31'b0, o_err}, {31'b0, mon_e.err});
        if (mon_e.lat_chk) chk("rsp_latency", cyc - mon_e.acc, mon_e.lat);
      end else $error("FAIL rsp_order: observed unexpected response rd=%h, expected none", o_rd);
    end
  end

  task automatic do_req(input logic rw, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input bit lat_chk);
    int   n;
    int   k;
    logic oor;
    sb_t  e;
    d_req_valid = 1'b1;
    d_rw        = rw;
    d_addr      = a;
    d_wd        = wd;
    d_be        = be;
    n           = 0;
    @(negedge clk);
    while (!o_req_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (n >= 400) chk("req_ready_timeout", {31'b0, o_req_ready}, 32'd1);
    k   = sel ? 1 : 0;
    oor = (a[31:10] != 22'd0);
    e.err     = oor;
    e.acc     = cyc;
    e.lat_chk = lat_chk;
    e.lat     = sel ? 3 : 1;
    if (rw) begin
      e.rd = 32'd0;
      if (!oor) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model[k][a[9:2]][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end else begin
      e.rd = oor ? 32'd0 : model[k][a[9:2]];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    d_req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int n;
    sb.delete();
    d_req_valid = 1'b0;
    rst_n       = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifdef VR_DMEM_CLR_ON_RST_EN
    n = 0;
    @(negedge clk);
    while (!o_req_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("clr_ready_low_cycles", n, 32'd256);
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 256; w++) model[k][w] = 32'd0;
    end
    @(posedge clk);
    #1;
`else
    n = 0;
`endif
  endtask

  initial begin
    logic [31:0] cap_rd;
    logic        cap_err;
    sel         = 1'b0;
    d_req_valid = 1'b0;
    d_addr      = '0;
    d_rw        = 1'b0;
    d_wd        = '0;
    d_be        = '0;
    d_rsp_ready = 1'b1;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    @(negedge clk);
    chk("reset_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
    chk("reset_rd", o_rd, 32'd0);
    chk("reset_err", {31'b0, o_err}, 32'd0);
    chk("reset_req_ready", {31'b0, o_req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // RD_LAT=1: basic write/read, byte lanes, out-of-range
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
    drain();
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
    drain();
    do_req(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1'b0);
    do_req(1'b1, 32'h400, 32'h12345678, 4'hF, 1'b1);
    do_req(1'b0, 32'h400, 32'h0, 4'h0, 1'b1);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    drain();

    // RD_LAT=3: preload and back-to-back reads
    sel = 1'b1;
    do_req(1'b1, 32'h0, 32'd1, 4'hF, 1'b0);
    do_req(1'b1, 32'h4, 32'd2, 4'hF, 1'b0);
    do_req(1'b1, 32'h8, 32'd3, 4'hF, 1'b0);
    drain();
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    do_req(1'b0, 32'h4, 32'h0, 4'h0, 1'b1);
    do_req(1'b0, 32'h8, 32'h0, 4'h0, 1'b1);
    drain();

    // Back-pressure: consumer stalls for 5 cycles in the middle of a read stream
    fork
      begin
        for (int i = 0; i < 8; i++) do_req(1'b0, 32'((i % 3) * 4), 32'h0, 4'h0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        d_rsp_ready = 1'b0;
        @(negedge clk);
        cap_rd  = o_rd;
        cap_err = o_err;
        for (int s = 0; s < 5; s++) begin
          if (s != 0) @(negedge clk);
          chk("bp_req_ready", {31'b0, o_req_ready}, 32'd0);
          chk("bp_rsp_valid", {31'b0, o_rsp_valid}, 32'd1);
          chk("bp_rd_stable", o_rd, cap_rd);
          chk("bp_err_stable", {31'b0, o_err}, {31'b0, cap_err});
        end
        @(posedge clk);
        #1;
        d_rsp_ready = 1'b1;
      end
    join
    drain();

    // Reset with a write completed and a read in flight
    do_req(1'b1, 32'h30, 32'h00000055, 4'hF, 1'b0);
    do_req(1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
      chk("rst_mid_rd", o_rd, 32'd0);
    end
    @(posedge clk);
    #1;
    do_req(1'b0, 32'h30, 32'h0, 4'h0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
